mcycle_ctrl: RTL and testbench

- Sequencer for an iterative multiply/divide unit that sits in the Execute stage beside the hazard unit.
- Accepts a multi-cycle instruction from E and iterates one step per cycle.
- Drives a busy request, ORed by the top level into StallF/StallD, an E-stage hold and an M-stage bubble, so the pipeline supports multi-cycle stalls.
- Presents registered results to the E-stage result mux.

---
 rtl/mcycle_ctrl.sv | 95 +++++++++
 tb/tb_mcycle_ctrl.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/mcycle_ctrl.sv
// mcycle_ctrl: sequencer for the iterative E-stage multiply/divide unit.
// It computes one product or quotient bit per cycle and stalls F/D/E until the result is registered.
module mcycle_ctrl #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             CLK,
   input  logic             Reset_n,
   input  logic             StartE,
   input  logic             MCycleOpE,
   input  logic [WIDTH-1:0] Operand1E,
   input  logic [WIDTH-1:0] Operand2E,
   input  logic             Abort,
   output logic             BusyE,
   output logic             DoneE,
   output logic [WIDTH-1:0] Result1E,
   output logic [WIDTH-1:0] Result2E
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic op_q, op_d;
   logic [WIDTH-1:0] src_q, src_d, opd_q, opd_d, res1_q, res1_d, res2_q, res2_d, diff;
   logic [2*WIDTH-1:0] acc_q, acc_d, step;
   logic [WIDTH:0] rem_sh;
   logic last;
   assign last = cnt_q == CNT_W'(WIDTH-1);
   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         op_q    <= 1'b0;
         src_q   <= '0;
         opd_q   <= '0;
         acc_q   <= '0;
         res1_q  <= '0;
         res2_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         src_q   <= src_d;
         opd_q   <= opd_d;
         acc_q   <= acc_d;
         res1_q  <= res1_d;
         res2_q  <= res2_d;
      end
   end
   always_comb begin
      state_d = IDLE;
      if (!Abort) begin
         if (state_q == IDLE && StartE) state_d = RUN;
         else if (state_q == RUN) state_d = last ? DONE : RUN;
      end
   end
   // src_q shifts out the multiplier (MUL) or dividend (DIV) MSB first; acc_q is {hi, lo}
   always_comb begin
      rem_sh = {acc_q[2*WIDTH-1:WIDTH], src_q[WIDTH-1]};
      diff   = rem_sh[WIDTH-1:0] - opd_q;
      step   = op_q ? (rem_sh >= {1'b0, opd_q} ? {diff, acc_q[WIDTH-2:0], 1'b1}
                                               : {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0})
                    : {acc_q[2*WIDTH-2:0], 1'b0} + (src_q[WIDTH-1] ? {{WIDTH{1'b0}}, opd_q} : '0);
   end
   always_comb begin
      op_d   = op_q;
      src_d  = src_q;
      opd_d  = opd_q;
      acc_d  = acc_q;
      cnt_d  = cnt_q;
      res1_d = res1_q;
      res2_d = res2_q;
      if (Abort) cnt_d = '0;
      else if (state_q == IDLE && StartE) begin
         op_d  = MCycleOpE;
         src_d = MCycleOpE ? Operand1E : Operand2E;
         opd_d = MCycleOpE ? Operand2E : Operand1E;
         acc_d = '0;
         cnt_d = '0;
      end else if (state_q == RUN) begin
         acc_d = step;
         src_d = {src_q[WIDTH-2:0], 1'b0};
         cnt_d = cnt_q + CNT_W'(1);
         if (last) begin
            res1_d = step[WIDTH-1:0];
            res2_d = step[2*WIDTH-1:WIDTH];
         end
      end
   end
   always_comb begin
      BusyE = Reset_n && !Abort && (state_q == RUN || (state_q == IDLE && StartE));
      DoneE = state_q == DONE;
   end
   assign Result1E = res1_q;
   assign Result2E = res2_q;
endmodule

// File: tb/tb_mcycle_ctrl.sv
// tb_mcycle_ctrl: directed checks of latency, busy window, results, abort and async reset.
module tb_mcycle_ctrl;
   logic        CLK = 1'b0;
   logic        Reset_n = 1'b0;
   logic        StartE = 1'b0;
   logic        MCycleOpE = 1'b0;
   logic [31:0] Operand1E = '0;
   logic [31:0] Operand2E = '0;
   logic        Abort = 1'b0;
   logic        BusyE, DoneE;
   logic [31:0] Result1E, Result2E;
   int checks = 0;
   int errors = 0;
   int k, n, dones;

   mcycle_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
      .CLK(CLK), .Reset_n(Reset_n), .StartE(StartE), .MCycleOpE(MCycleOpE),
      .Operand1E(Operand1E), .Operand2E(Operand2E), .Abort(Abort),
      .BusyE(BusyE), .DoneE(DoneE), .Result1E(Result1E), .Result2E(Result2E)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge CLK);
      #2;
   endtask

   // counts cycles (and busy cycles) from the current one until DoneE, bounded
   task automatic wait_done(output int kk, output int nn);
      kk = 0;
      nn = 0;
      while (!DoneE && kk < 80) begin
         if (BusyE) nn++;
         cyc();
         kk++;
      end
   endtask

   task automatic do_op(input string tag, input logic op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] e1, input logic [31:0] e2);
      int kk, nn;
      StartE = 1'b1;
      MCycleOpE = op;
      Operand1E = a;
      Operand2E = b;
      #1;
      chk({tag, "_busy_start"}, 32'(BusyE), 32'd1);
      cyc();
      Operand1E = ~a;
      Operand2E = ~b;
      #1;
      wait_done(kk, nn);
      chk({tag, "_latency"}, 32'(kk + 1), 32'd33);
      chk({tag, "_busy_cycles"}, 32'(nn + 1), 32'd33);
      chk({tag, "_busy_in_done"}, 32'(BusyE), 32'd0);
      chk({tag, "_r1"}, Result1E, e1);
      chk({tag, "_r2"}, Result2E, e2);
      StartE = 1'b0;
      cyc();
      chk({tag, "_done_pulse"}, 32'(DoneE), 32'd0);
      chk({tag, "_r1_hold"}, Result1E, e1);
   endtask

   initial begin
      #3;
      chk("rst_busy", 32'(BusyE), 32'd0);
      chk("rst_done", 32'(DoneE), 32'd0);
      chk("rst_r1", Result1E, 32'd0);
      chk("rst_r2", Result2E, 32'd0);
      cyc();
      Reset_n = 1'b1;
      cyc();
      do_op("mul7x6", 1'b0, 32'd7, 32'd6, 32'h0000002A, 32'h0);
      do_op("mulmax", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE);
      do_op("div100_7", 1'b1, 32'd100, 32'd7, 32'd14, 32'd2);
      do_op("div5_0", 1'b1, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5);
      // back-to-back multiplies with StartE held
      StartE = 1'b1;
      MCycleOpE = 1'b0;
      Operand1E = 32'd3;
      Operand2E = 32'd4;
      #1;
      wait_done(k, n);
      chk("b2b_first_lat", 32'(k), 32'd33);
      chk("b2b_first_r1", Result1E, 32'd12);
      chk("b2b_first_r2", Result2E, 32'd0);
      Operand1E = 32'd5;
      Operand2E = 32'd5;
      cyc();
      chk("b2b_idle_busy", 32'(BusyE), 32'd1);
      chk("b2b_idle_done", 32'(DoneE), 32'd0);
      wait_done(k, n);
      chk("b2b_gap", 32'(k + 1), 32'd34);
      chk("b2b_busy_cycles", 32'(n), 32'd33);
      chk("b2b_done_busy", 32'(BusyE), 32'd0);
      chk("b2b_second_r1", Result1E, 32'd25);
      StartE = 1'b0;
      cyc();
      // abort in the 10th RUN cycle
      StartE = 1'b1;
      Operand1E = 32'd9;
      Operand2E = 32'd9;
      #1;
      for (int i = 0; i < 10; i++) cyc();
      Abort = 1'b1;
      #1;
      chk("abort_busy", 32'(BusyE), 32'd0);
      cyc();
      Abort = 1'b0;
      StartE = 1'b0;
      #1;
      chk("abort_idle_busy", 32'(BusyE), 32'd0);
      dones = 0;
      for (int i = 0; i < 40; i++) begin
         if (DoneE) dones++;
         cyc();
      end
      chk("abort_no_done", 32'(dones), 32'd0);
      chk("abort_r1", Result1E, 32'd25);
      chk("abort_r2", Result2E, 32'd0);
      // async reset mid-RUN with StartE held
      StartE = 1'b1;
      Operand1E = 32'd2;
      Operand2E = 32'd3;
      #1;
      for (int i = 0; i < 5; i++) cyc();
      Reset_n = 1'b0;
      #1;
      chk("mrst_busy", 32'(BusyE), 32'd0);
      chk("mrst_done", 32'(DoneE), 32'd0);
      chk("mrst_r1", Result1E, 32'd0);
      chk("mrst_r2", Result2E, 32'd0);
      #1;
      Reset_n = 1'b1;
      #1;
      wait_done(k, n);
      chk("mrst_lat", 32'(k), 32'd33);
      chk("mrst_busy_cycles", 32'(n), 32'd33);
      chk("mrst_r1_after", Result1E, 32'd6);
      StartE = 1'b0;
      cyc();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
